booth_div: RTL

Sequential radix-2 restoring divider, the inverse datapath of the Booth multiply-accumulate unit. It takes a 2W-bit dividend, such as an accumulated MAC result, and a W-bit divisor. It produces a W-bit quotient and a W-bit remainder, computing one quotient bit per clock. It sits beside the multiplier in the arithmetic cluster and uses the same start/ready style of handshake.

---
 rtl/booth_div_pkg.sv | 20 ++
 rtl/booth_div_if.sv | 32 +++
 rtl/booth_div_step.sv | 29 ++
 rtl/booth_div.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_div_pkg.sv
// booth_pkg: shared definitions for the booth_div sequential divider.
//   DEF_WIDTH    - default operand width W (dividend is 2W bits)
//   state_t      - divider FSM state encoding (2 bits)
//   SAT_POS_MASK - source pattern for the signed saturation constants;
//                  the top slices the upper WIDTH bits (0x7FFF for W=16)
//                  and uses its complement for the negative limit (0x8000).
package booth_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [63:0] SAT_POS_MASK = 64'h7FFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/booth_div_if.sv
// booth_div_if: start/ready handshake and operand/result bundle of booth_div.
//   start, dividend[2W-1:0], divisor[W-1:0]       requester -> divider
//   quotient, remainder, done, busy,
//   div_by_zero, overflow                         divider -> requester
// Modports: master (requester side), slave (divider side).
interface booth_div_if
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 done;
  logic                 busy;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero, overflow
  );

endinterface

// File: rtl/booth_div_step.sv
// div_step: one restoring-division iteration (purely combinational).
//   r_in    - current partial remainder R (always < divisor)
//   q_msb   - MSB of the quotient/dividend shift register, shifted into R
//   divisor - divisor magnitude
//   r_out   - next partial remainder
//   q_bit   - quotient bit produced by this iteration
module div_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  // The shifted trial needs W+1 bits: R < divisor <= 2^W-1 means 2R+1 can
  // exceed W bits, but after a successful subtract the result fits again.
  logic [WIDTH:0] trial;

  always_comb begin
    trial = {r_in, q_msb};
    q_bit = (trial >= {1'b0, divisor});
    r_out = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/booth_div.sv
// booth_div: sequential radix-2 restoring divider, 2W-bit dividend by
// W-bit divisor, one quotient bit per clock.
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - booth_div_if.slave: start/dividend/divisor in;
//            quotient/remainder/done/busy/div_by_zero/overflow out
// Optional feature macro: DIV_SIGNED_EN (two's complement operands,
// truncating division with saturating overflow). Undefined: unsigned only.
module booth_div
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  booth_div_if.slave    bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dsr_mag;
  logic [WIDTH-1:0]   step_r;
  logic               step_q;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] SAT_POS = SAT_POS_MASK[63 -: WIDTH];
  localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;

  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic dvd_neg, dsr_neg;

  assign dvd_neg = bus.dividend[2*WIDTH-1];
  assign dsr_neg = bus.divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
  assign dsr_mag = dsr_neg ? -bus.divisor  : bus.divisor;
`else
  assign dvd_mag = bus.dividend;
  assign dsr_mag = bus.divisor;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .q_msb   (q_q[WIDTH-1]),
    .divisor (dsr_q),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dsr_d   = dsr_q;
    lo_d    = lo_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          r_d   = dvd_mag[2*WIDTH-1:WIDTH];
          q_d   = dvd_mag[WIDTH-1:0];
          dsr_d = dsr_mag;
          lo_d  = bus.dividend[WIDTH-1:0];
          cnt_d = CW'(WIDTH);
          dbz_d = 1'b0;
          ovf_d = 1'b0;
`ifdef DIV_SIGNED_EN
          qneg_d = dvd_neg ^ dsr_neg;
          rneg_d = dvd_neg;
`endif
          if (dsr_mag == '0) begin
            dbz_d   = 1'b1;
            state_d = FIXUP;
          end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dsr_mag) begin
            // Quotient would not fit in W bits.
            ovf_d   = 1'b1;
            state_d = FIXUP;
          end else begin
            state_d = ITER;
          end
        end
      end

      ITER: begin
        r_d   = step_r;
        q_d   = {q_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        done_d  = 1'b1;
        state_d = DONE;
        if (dbz_q) begin
          quot_d = '1;
          rem_d  = lo_q;
        end else if (ovf_q) begin
`ifdef DIV_SIGNED_EN
          quot_d = qneg_q ? SAT_NEG : SAT_POS;
`else
          quot_d = '1;
`endif
          rem_d  = '0;
        end else begin
`ifdef DIV_SIGNED_EN
          // Magnitude quotient may still exceed the signed range even
          // though the unsigned pre-check passed.
          if (qneg_q ? (q_q > SAT_NEG) : (q_q > SAT_POS)) begin
            ovf_d  = 1'b1;
            quot_d = qneg_q ? SAT_NEG : SAT_POS;
            rem_d  = '0;
          end else begin
            quot_d = qneg_q ? -q_q : q_q;
            rem_d  = rneg_q ? -r_q : r_q;
          end
`else
          quot_d = q_q;
          rem_d  = r_q;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dsr_q   <= '0;
      lo_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dsr_q   <= dsr_d;
      lo_q    <= lo_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
